ps2_scan_decoder: RTL and testbench

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_evt_fifo.sv | 50 +++++
 rtl/ps2_scan_decoder.sv | 176 +++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, decoder state encoding and the event record.
package ps2_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_BAT      = 8'hAA;
  localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
  localparam logic [7:0] SC_ERR_LO   = 8'h00;
  localparam logic [7:0] SC_ERR_HI   = 8'hFF;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_ECHO     = 8'hEE;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_ALT      = 8'h11;

  // Bytes following the E1 that opens the Pause/Break sequence.
  localparam int unsigned PAUSE_TAIL = 7;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  function automatic ps2_evt_t mk_evt(input logic [7:0] code, input logic ext, input logic brk);
    ps2_evt_t e;
    e.code = code;
    e.ext  = ext;
    e.brk  = brk;
    return e;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO: push/full write side, valid/ready read side, zeroed head when empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  ps2_evt_t i_wdata,
  output logic     o_full,
  output logic     o_vld,
  input  logic     i_rdy,
  output ps2_evt_t o_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  ps2_evt_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push;
  logic          pop;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_vld   = (cnt_q != '0);
  assign pop     = o_vld && i_rdy;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push    = i_push && (!o_full || pop);
  assign o_rdata = o_vld ? mem_q[rd_q] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!push && pop) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= i_wdata;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, modifier tracking, inter-byte timeout, buffered key events.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_vld,
  output logic       o_evt_vld,
  input  logic       i_evt_rdy,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_brk,
  output logic [2:0] o_mod,
  output logic       o_bat_ok,
  output logic       o_err,
  output logic       o_ovf
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e state_q, state_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic lsh_q, lsh_d, rsh_q, rsh_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic bat_q, bat_d, err_q, err_d, ovf_q, ovf_d;
  logic     emit;
  ps2_evt_t evt;
  ps2_evt_t head;
  logic     fifo_full;
  logic     pop;
  logic     push;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    emit    = 1'b0;
    evt     = '0;
    bat_d   = 1'b0;
    err_d   = 1'b0;
    if (i_byte_vld) begin
      // A byte landing on the timeout cycle is decoded; the timeout is skipped.
      tcnt_d = '0;
      unique case (state_q)
        IDLE: begin
          case (i_byte)
            SC_EXT:   state_d = EXT;
            SC_BRK:   state_d = BRK;
            SC_PAUSE: begin
              state_d = PAUSE;
              pcnt_d  = '0;
            end
            SC_BAT:                           bat_d = 1'b1;
            SC_BAT_FAIL, SC_ERR_LO, SC_ERR_HI: err_d = 1'b1;
            SC_ACK, SC_RESEND, SC_ECHO:       ;
            default: begin
              emit = 1'b1;
              evt  = mk_evt(i_byte, 1'b0, 1'b0);
            end
          endcase
        end
        EXT: begin
          if (i_byte == SC_BRK) begin
            state_d = EXT_BRK;
          end else begin
            emit    = 1'b1;
            evt     = mk_evt(i_byte, 1'b1, 1'b0);
            state_d = IDLE;
          end
        end
        BRK: begin
          emit    = 1'b1;
          evt     = mk_evt(i_byte, 1'b0, 1'b1);
          state_d = IDLE;
        end
        EXT_BRK: begin
          emit    = 1'b1;
          evt     = mk_evt(i_byte, 1'b1, 1'b1);
          state_d = IDLE;
        end
        PAUSE: begin
          if (pcnt_q == 3'(PAUSE_TAIL - 1)) begin
            emit    = 1'b1;
            evt     = mk_evt(SC_PAUSE, 1'b0, 1'b0);
            state_d = IDLE;
          end else begin
            pcnt_d = pcnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  always_comb begin
    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    ctrl_d = ctrl_q;
    alt_d  = alt_q;
    if (emit) begin
      case (evt.code)
        SC_LSHIFT: if (!evt.ext) lsh_d = !evt.brk;
        SC_RSHIFT: if (!evt.ext) rsh_d = !evt.brk;
        SC_CTRL:   ctrl_d = !evt.brk;
        SC_ALT:    alt_d  = !evt.brk;
        default:   ;
      endcase
    end
  end

  assign pop   = o_evt_vld && i_evt_rdy;
  assign push  = emit && (!fifo_full || pop);
  assign ovf_d = emit && fifo_full && !pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      alt_q   <= 1'b0;
      bat_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      ctrl_q  <= ctrl_d;
      alt_q   <= alt_d;
      bat_q   <= bat_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_wdata(evt),
    .o_full (fifo_full),
    .o_vld  (o_evt_vld),
    .i_rdy  (i_evt_rdy),
    .o_rdata(head)
  );

  assign o_evt_code = head.code;
  assign o_evt_ext  = head.ext;
  assign o_evt_brk  = head.brk;
  assign o_mod      = {alt_q, ctrl_q, lsh_q | rsh_q};
  assign o_bat_ok   = bat_q;
  assign o_err      = err_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: vector table of byte sequences plus FIFO, timeout and reset corners.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bval;
  logic       bvld;
  logic       evt_rdy;
  logic       evt_vld;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic [2:0] mod;
  logic       bat_ok;
  logic       err;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    logic       vld;
    logic [7:0] code;
    logic       ext, brk;
    logic [2:0] mod;
    logic       bat, err;
  } vec_t;

  vec_t vecs[$];

  ps2_scan_decoder #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_byte    (bval),
    .i_byte_vld(bvld),
    .o_evt_vld (evt_vld),
    .i_evt_rdy (evt_rdy),
    .o_evt_code(evt_code),
    .o_evt_ext (evt_ext),
    .o_evt_brk (evt_brk),
    .o_mod     (mod),
    .o_bat_ok  (bat_ok),
    .o_err     (err),
    .o_ovf     (ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                              logic vld, logic [7:0] code, logic ext, logic brk,
                              logic [2:0] m, logic bat, logic e);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.vld = vld; v.code = code; v.ext = ext; v.brk = brk;
    v.mod = m; v.bat = bat; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bval = b;
    bvld = 1'b1;
    @(negedge clk);
    bvld = 1'b0;
  endtask

  task automatic pop1();
    evt_rdy = 1'b1;
    @(negedge clk);
    evt_rdy = 1'b0;
  endtask

  task automatic chk_evt(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, "_vld"}, evt_vld, 1'b1);
    chk({tag, "_code"}, evt_code, code);
    chk({tag, "_ext"}, evt_ext, ext);
    chk({tag, "_brk"}, evt_brk, brk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pz [8];
    logic [7:0] mk6 [6];
    logic [7:0] b;
    int cyc;
    int ovf_seen;

    vecs.push_back(mk(1, 8'h1C, 8'h00, 8'h00, 1, 8'h1C, 0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h1C, 8'h00, 1, 8'h1C, 0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h75, 1, 8'h75, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h75, 8'h00, 1, 8'h75, 1, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 8'h12, 8'h00, 8'h00, 1, 8'h12, 0, 0, 3'b001, 0, 0));
    vecs.push_back(mk(1, 8'h14, 8'h00, 8'h00, 1, 8'h14, 0, 0, 3'b011, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h12, 8'h00, 1, 8'h12, 0, 1, 3'b010, 0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h11, 8'h00, 1, 8'h11, 1, 0, 3'b110, 0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h12, 8'h00, 1, 8'h12, 1, 0, 3'b110, 0, 0));
    vecs.push_back(mk(1, 8'h59, 8'h00, 8'h00, 1, 8'h59, 0, 0, 3'b111, 0, 0));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h14, 1, 8'h14, 1, 1, 3'b101, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h59, 8'h00, 1, 8'h59, 0, 1, 3'b100, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h11, 8'h00, 1, 8'h11, 0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'hAA, 8'h00, 1, 8'hAA, 0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'b000, 1, 0));
    vecs.push_back(mk(1, 8'hFC, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'b000, 0, 1));
    vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'b000, 0, 1));
    vecs.push_back(mk(1, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'b000, 0, 1));
    vecs.push_back(mk(1, 8'hFA, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 8'hFE, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 8'hEE, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'b000, 0, 0));

    rst = 1'b1; bvld = 1'b0; bval = '0; evt_rdy = 1'b0;
    #12;
    chk("rst_vld", evt_vld, 1'b0);
    chk("rst_code", evt_code, 8'h00);
    chk("rst_mod", mod, 3'b000);
    chk("rst_pulses", {bat_ok, err, ovf}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++)
        send(k == 0 ? vecs[i].b0 : (k == 1 ? vecs[i].b1 : vecs[i].b2));
      chk($sformatf("v%0d_vld", i), evt_vld, vecs[i].vld);
      chk($sformatf("v%0d_code", i), evt_code, vecs[i].code);
      chk($sformatf("v%0d_ext", i), evt_ext, vecs[i].ext);
      chk($sformatf("v%0d_brk", i), evt_brk, vecs[i].brk);
      chk($sformatf("v%0d_mod", i), mod, vecs[i].mod);
      chk($sformatf("v%0d_bat", i), bat_ok, vecs[i].bat);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_ovf", i), ovf, 1'b0);
      pop1();
      chk($sformatf("v%0d_empty", i), evt_vld, 1'b0);
      chk($sformatf("v%0d_pulse_w", i), {bat_ok, err}, 2'b00);
    end

    // Pause/Break: eight bytes, one event, modifiers untouched
    pz = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int k = 0; k < 8; k++) begin
      send(pz[k]);
      if (k < 7) chk($sformatf("pause_b%0d_vld", k), evt_vld, 1'b0);
    end
    chk_evt("pause", 8'hE1, 1'b0, 1'b0);
    chk("pause_mod", mod, 3'b000);
    pop1();
    chk("pause_single", evt_vld, 1'b0);

    // Full FIFO with simultaneous pop: push accepted, no overflow
    mk6 = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    for (int k = 0; k < 4; k++) begin
      send(mk6[k]);
      chk($sformatf("fill_ovf%0d", k), ovf, 1'b0);
    end
    bval = 8'h24; bvld = 1'b1; evt_rdy = 1'b1;
    @(negedge clk);
    bvld = 1'b0; evt_rdy = 1'b0;
    chk("fullpop_ovf", ovf, 1'b0);
    for (int k = 1; k < 5; k++) begin
      chk_evt($sformatf("fullpop_d%0d", k), mk6[k], 1'b0, 1'b0);
      pop1();
    end
    chk("fullpop_empty", evt_vld, 1'b0);

    // Six makes into depth-4 FIFO with no consumer
    ovf_seen = 0;
    for (int k = 0; k < 6; k++) begin
      send(mk6[k]);
      chk($sformatf("ovf_k%0d", k), ovf, (k >= 4) ? 1'b1 : 1'b0);
      if (ovf === 1'b1) ovf_seen++;
    end
    @(negedge clk);
    chk("ovf_pulse_w", ovf, 1'b0);
    chk("ovf_count", ovf_seen, 2);
    for (int k = 0; k < 4; k++) begin
      chk_evt($sformatf("drain%0d", k), mk6[k], 1'b0, 1'b0);
      pop1();
    end
    chk("drain_empty", evt_vld, 1'b0);

    // Timeout after a dangling E0
    send(8'hE0);
    cyc = 0;
    while (err !== 1'b1 && cyc < 3 * TO) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_cycles", cyc, TO);
    chk("to_no_evt", evt_vld, 1'b0);
    @(negedge clk);
    chk("to_pulse_w", err, 1'b0);
    send(8'h1C);
    chk_evt("after_to", 8'h1C, 1'b0, 1'b0);
    pop1();

    // Byte arriving on the timeout cycle wins
    send(8'hE0);
    repeat (TO - 1) @(negedge clk);
    send(8'h75);
    chk("edge_err", err, 1'b0);
    chk_evt("edge_evt", 8'h75, 1'b1, 1'b0);
    pop1();

    // Asynchronous reset mid-sequence
    send(8'h12);
    chk("prerst_mod", mod, 3'b001);
    send(8'hF0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", evt_vld, 1'b0);
    chk("arst_code", evt_code, 8'h00);
    chk("arst_mod", mod, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b = 8'h1C;
    send(b);
    chk_evt("postrst", 8'h1C, 1'b0, 1'b0);
    chk("postrst_mod", mod, 3'b000);
    pop1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
